ecc_sram_scrub: RTL

Parametrised single-port SRAM with SEC-DED Hamming protection, automatic write-back of corrected words and an idle-time background scrubber. It generalises the 256x8 Hamming memory in data width and depth and replaces testbench `force` with a port-level error-injection path. It sits behind the core's memory interface, and its counters feed the status/CSR block.

---
 rtl/ecc_sram_scrub.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ecc_sram_scrub.sv
// SEC-DED protected single-port SRAM with corrected-word write-back and an
// idle-time background scrubber that walks the array one word at a time.
`timescale 1ns/1ps
module ecc_sram_scrub #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int SCRUB_GAP = 16,
  parameter int CNT_W     = 8,
  localparam int P = (DATA_W <= 4)  ? 3 : (DATA_W <= 11) ? 4 :
                     (DATA_W <= 26) ? 5 : (DATA_W <= 57) ? 6 :
                     (DATA_W <= 120) ? 7 : 8,
  localparam int CW_W = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              inj_en,
  input  logic [CW_W-1:0]   inj_mask,
  input  logic              scrub_en,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] data_out,
  output logic              sec_err,
  output logic              ded_err,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt,
  output logic [ADDR_W-1:0] err_addr
);

  // state  | meaning
  // S_IDLE | accept requests, count idle cycles toward the next scrub
  // S_RD   | decode port read, present data and flags
  // S_WB   | write corrected port-read word back
  // S_SCHK | decode scrub read, update counters, advance scrub pointer
  // S_SWB  | write corrected scrub word back
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WB, S_SCHK, S_SWB} state_t;

  localparam int IC_W = $clog2(SCRUB_GAP + 1);

  function automatic logic [CW_W-1:0] enc(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] cw;
    int k;
    cw = '0;
    k  = 0;
    for (int i = 1; i < CW_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        cw[i] = d[k];
        k++;
      end
    end
    for (int j = 0; j < P; j++) begin
      for (int i = 1; i < CW_W; i++) begin
        if (((i >> j) & 1) == 1 && i != (1 << j)) cw[1 << j] = cw[1 << j] ^ cw[i];
      end
    end
    cw[0] = ^cw[CW_W-1:1];
    return cw;
  endfunction

  function automatic logic [P-1:0] syndrome(input logic [CW_W-1:0] cw);
    logic [P-1:0] s;
    s = '0;
    for (int i = 1; i < CW_W; i++) begin
      if (cw[i]) s = s ^ P'(i);
    end
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int i = 1; i < CW_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[k] = cw[i];
        k++;
      end
    end
    return d;
  endfunction

  logic [CW_W-1:0]   mem [2**ADDR_W];
  state_t            state_q;
  logic [CW_W-1:0]   rd_cw_q;
  logic [ADDR_W-1:0] op_addr_q;
  logic [ADDR_W-1:0] scrub_ptr_q;
  logic [IC_W-1:0]   idle_cnt_q;
  logic              rvalid_q, sec_err_q, ded_err_q;
  logic [DATA_W-1:0] data_out_q;
  logic [CNT_W-1:0]  sec_cnt_q, ded_cnt_q;
  logic [ADDR_W-1:0] err_addr_q;

  logic [P-1:0]      dec_syn;
  logic              dec_perr, dec_sec, dec_ded;
  logic [CW_W-1:0]   dec_fix;
  logic [DATA_W-1:0] dec_data;

  // A parity error with an out-of-range syndrome cannot be a single flip.
  always_comb begin
    dec_syn  = syndrome(rd_cw_q);
    dec_perr = ^rd_cw_q;
    dec_fix  = rd_cw_q;
    dec_sec  = 1'b0;
    dec_ded  = 1'b0;
    if (dec_perr) begin
      if (dec_syn == '0) begin
        dec_fix[0] = ~dec_fix[0];
        dec_sec    = 1'b1;
      end else if (int'(dec_syn) < CW_W) begin
        for (int i = 1; i < CW_W; i++) begin
          if (P'(i) == dec_syn) dec_fix[i] = ~dec_fix[i];
        end
        dec_sec = 1'b1;
      end else begin
        dec_ded = 1'b1;
      end
    end else if (dec_syn != '0) begin
      dec_ded = 1'b1;
    end
    dec_data = extract(dec_fix);
  end

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [CW_W-1:0]   mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = enc(data_in) ^ (inj_en ? inj_mask : '0);
    if (state_q == S_IDLE && enable && we) begin
      mem_we = 1'b1;
    end else if (state_q == S_WB || state_q == S_SWB) begin
      mem_we    = 1'b1;
      mem_waddr = op_addr_q;
      mem_wdata = enc(dec_data);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rd_cw_q     <= '0;
      op_addr_q   <= '0;
      scrub_ptr_q <= '0;
      idle_cnt_q  <= '0;
      rvalid_q    <= 1'b0;
      sec_err_q   <= 1'b0;
      ded_err_q   <= 1'b0;
      data_out_q  <= '0;
      sec_cnt_q   <= '0;
      ded_cnt_q   <= '0;
      err_addr_q  <= '0;
    end else begin
      rvalid_q  <= 1'b0;
      sec_err_q <= 1'b0;
      ded_err_q <= 1'b0;
      if (state_q == S_RD || state_q == S_SCHK) begin
        if (dec_ded && ded_cnt_q != {CNT_W{1'b1}}) ded_cnt_q <= ded_cnt_q + CNT_W'(1);
        if (dec_sec && sec_cnt_q != {CNT_W{1'b1}}) sec_cnt_q <= sec_cnt_q + CNT_W'(1);
        if (dec_sec || dec_ded) err_addr_q <= op_addr_q;
      end
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            idle_cnt_q <= '0;
            if (!we) begin
              rd_cw_q   <= mem[addr];
              op_addr_q <= addr;
              state_q   <= S_RD;
            end
          end else if (scrub_en) begin
            if (int'(idle_cnt_q) + 1 >= SCRUB_GAP) begin
              idle_cnt_q <= '0;
              rd_cw_q    <= mem[scrub_ptr_q];
              op_addr_q  <= scrub_ptr_q;
              state_q    <= S_SCHK;
            end else begin
              idle_cnt_q <= idle_cnt_q + IC_W'(1);
            end
          end else begin
            idle_cnt_q <= '0;
          end
        end
        S_RD: begin
          rvalid_q   <= 1'b1;
          data_out_q <= dec_data;
          sec_err_q  <= dec_sec;
          ded_err_q  <= dec_ded;
          state_q    <= dec_sec ? S_WB : S_IDLE;
        end
        S_SCHK: begin
          scrub_ptr_q <= scrub_ptr_q + ADDR_W'(1);
          state_q     <= dec_sec ? S_SWB : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign rvalid   = rvalid_q;
  assign data_out = data_out_q;
  assign sec_err  = sec_err_q;
  assign ded_err  = ded_err_q;
  assign sec_cnt  = sec_cnt_q;
  assign ded_cnt  = ded_cnt_q;
  assign err_addr = err_addr_q;

endmodule
